// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard controller: forwarding selects
// and branch-resolution FSM states.
package hazard_pkg;

  typedef logic [1:0] fwd_sel_t;

  localparam fwd_sel_t FWD_NONE = 2'b00;
  localparam fwd_sel_t FWD_MEM  = 2'b01;
  localparam fwd_sel_t FWD_EXE  = 2'b10;

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_BR_PEND = 1'b1;

  localparam int unsigned MDU_CNT_W = 4;

endpackage

// File: rtl/hazard_raw_cmp.sv
// Compares one ID source register against the EXE and MEM destinations.
// Produces per-stage RAW match flags and the operand forwarding select.
module hazard_raw_cmp
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned FWD_EN = 1
) (
  input  logic              src_read,
  input  logic [REG_AW-1:0] src,
  input  logic              exe_reg_write,
  input  logic [REG_AW-1:0] exe_rdes,
  input  logic              mem_reg_write,
  input  logic [REG_AW-1:0] mem_rdes,
  output logic              exe_match,
  output logic              mem_match,
  output fwd_sel_t          fwd
);

  logic src_nonzero;

  assign src_nonzero = |src;

  // Register $0 is hard-wired to zero, so it never creates a dependency.
  always_comb begin
    exe_match = src_read & exe_reg_write & src_nonzero & (src == exe_rdes);
    mem_match = src_read & mem_reg_write & src_nonzero & (src == mem_rdes);
  end

  // EXE holds the younger result, so it wins over MEM when both match.
  always_comb begin
    fwd = FWD_NONE;
    if (FWD_EN != 0) begin
      if (exe_match) begin
        fwd = FWD_EXE;
      end else if (mem_match) begin
        fwd = FWD_MEM;
      end
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage core: RAW stall/forward
// decisions, branch-resolution fetch hold, and HI/LO interlock against the
// multi-cycle multiply/divide unit.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned FWD_EN  = 1,
  parameter int unsigned MDU_LAT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic              id_read_rs,
  input  logic              id_read_rt,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_is_branch,
  input  logic              id_is_mdu,
  input  logic              id_uses_hilo,
  input  logic              exe_reg_write,
  input  logic              exe_mem_read,
  input  logic [REG_AW-1:0] exe_rdes,
  input  logic              mem_reg_write,
  input  logic [REG_AW-1:0] mem_rdes,
  input  logic              br_resolved,
  output logic              pc_stall,
  output logic              if_id_stall,
  output logic              if_id_flush,
  output logic              id_exe_bubble,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              mdu_busy
);

  localparam logic [MDU_CNT_W-1:0] MDU_LAT_C = MDU_LAT[MDU_CNT_W-1:0];

  logic [0:0]           state_q, state_d;
  logic [MDU_CNT_W-1:0] cnt_q, cnt_d;

  logic     rs_exe, rs_mem, rt_exe, rt_mem;
  fwd_sel_t fwd_a_c, fwd_b_c;
  logic     data_stall, mdu_stall, hold, accept, busy;
  logic     pc_stall_c, if_id_stall_c, if_id_flush_c, id_exe_bubble_c;

  hazard_raw_cmp #(.REG_AW(REG_AW), .FWD_EN(FWD_EN)) u_cmp_rs (
    .src_read      (id_read_rs),
    .src           (id_rs),
    .exe_reg_write (exe_reg_write),
    .exe_rdes      (exe_rdes),
    .mem_reg_write (mem_reg_write),
    .mem_rdes      (mem_rdes),
    .exe_match     (rs_exe),
    .mem_match     (rs_mem),
    .fwd           (fwd_a_c)
  );

  hazard_raw_cmp #(.REG_AW(REG_AW), .FWD_EN(FWD_EN)) u_cmp_rt (
    .src_read      (id_read_rt),
    .src           (id_rt),
    .exe_reg_write (exe_reg_write),
    .exe_rdes      (exe_rdes),
    .mem_reg_write (mem_reg_write),
    .mem_rdes      (mem_rdes),
    .exe_match     (rt_exe),
    .mem_match     (rt_mem),
    .fwd           (fwd_b_c)
  );

  assign busy = (cnt_q != '0);

  // With forwarding only a load in EXE is unresolvable; without it any
  // in-flight producer in EXE or MEM must drain first.
  always_comb begin
    if (FWD_EN != 0) begin
      data_stall = (rs_exe | rt_exe) & exe_mem_read;
    end else begin
      data_stall = rs_exe | rt_exe | rs_mem | rt_mem;
    end
    mdu_stall = id_valid & id_uses_hilo & busy;
    hold      = id_valid & (data_stall | mdu_stall);
    accept    = id_valid & ~hold & (state_q == ST_IDLE);
  end

  // MDU occupancy: reload on an accepted mult/div, otherwise count down.
  always_comb begin
    cnt_d = cnt_q;
    if (accept && id_is_mdu) begin
      cnt_d = MDU_LAT_C;
    end else if (busy) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Branch FSM and pipeline-control priority; BR_PEND overrides data holds
  // because nothing new may leave ID until the branch outcome is known.
  always_comb begin
    state_d         = state_q;
    pc_stall_c      = 1'b0;
    if_id_stall_c   = 1'b0;
    if_id_flush_c   = 1'b0;
    id_exe_bubble_c = 1'b0;
    if (state_q == ST_BR_PEND) begin
      pc_stall_c    = ~br_resolved;
      if_id_flush_c = 1'b1;
      if (br_resolved) begin
        state_d = ST_IDLE;
      end
    end else if (hold) begin
      pc_stall_c      = 1'b1;
      if_id_stall_c   = 1'b1;
      id_exe_bubble_c = 1'b1;
    end else if (accept && id_is_branch) begin
      pc_stall_c    = 1'b1;
      if_id_flush_c = 1'b1;
      state_d       = ST_BR_PEND;
    end
  end

  // State and MDU counter registers; reset abandons any pending operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs are forced quiet for the whole time reset is asserted.
  always_comb begin
    pc_stall      = rst_n & pc_stall_c;
    if_id_stall   = rst_n & if_id_stall_c;
    if_id_flush   = rst_n & if_id_flush_c;
    id_exe_bubble = rst_n & id_exe_bubble_c;
    mdu_busy      = rst_n & busy;
    fwd_a         = rst_n ? fwd_a_c : FWD_NONE;
    fwd_b         = rst_n ? fwd_b_c : FWD_NONE;
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: one forwarding and one non-forwarding
// instance share the pipeline inputs but have separate id_valid lines.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       vf, vn;
  logic       read_rs, read_rt;
  logic [4:0] rs, rt;
  logic       is_branch, is_mdu, uses_hilo;
  logic       exe_w, exe_ld;
  logic [4:0] exe_rd;
  logic       mem_w;
  logic [4:0] mem_rd;
  logic       br_res;

  logic       pc_f, ifs_f, flu_f, bub_f, busy_f;
  logic [1:0] fa_f, fb_f;
  logic       pc_n, ifs_n, flu_n, bub_n, busy_n;
  logic [1:0] fa_n, fb_n;

  logic [3:0] ctl_f, ctl_n;
  assign ctl_f = {pc_f, ifs_f, flu_f, bub_f};
  assign ctl_n = {pc_n, ifs_n, flu_n, bub_n};

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.REG_AW(5), .FWD_EN(1), .MDU_LAT(4)) u_f (
    .clk(clk), .rst_n(rst_n), .id_valid(vf),
    .id_read_rs(read_rs), .id_read_rt(read_rt), .id_rs(rs), .id_rt(rt),
    .id_is_branch(is_branch), .id_is_mdu(is_mdu), .id_uses_hilo(uses_hilo),
    .exe_reg_write(exe_w), .exe_mem_read(exe_ld), .exe_rdes(exe_rd),
    .mem_reg_write(mem_w), .mem_rdes(mem_rd), .br_resolved(br_res),
    .pc_stall(pc_f), .if_id_stall(ifs_f), .if_id_flush(flu_f),
    .id_exe_bubble(bub_f), .fwd_a(fa_f), .fwd_b(fb_f), .mdu_busy(busy_f)
  );

  hazard_ctrl #(.REG_AW(5), .FWD_EN(0), .MDU_LAT(4)) u_n (
    .clk(clk), .rst_n(rst_n), .id_valid(vn),
    .id_read_rs(read_rs), .id_read_rt(read_rt), .id_rs(rs), .id_rt(rt),
    .id_is_branch(is_branch), .id_is_mdu(is_mdu), .id_uses_hilo(uses_hilo),
    .exe_reg_write(exe_w), .exe_mem_read(exe_ld), .exe_rdes(exe_rd),
    .mem_reg_write(mem_w), .mem_rdes(mem_rd), .br_resolved(br_res),
    .pc_stall(pc_n), .if_id_stall(ifs_n), .if_id_flush(flu_n),
    .id_exe_bubble(bub_n), .fwd_a(fa_n), .fwd_b(fb_n), .mdu_busy(busy_n)
  );

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    vf = 0; vn = 0; read_rs = 0; read_rt = 0; rs = 0; rt = 0;
    is_branch = 0; is_mdu = 0; uses_hilo = 0;
    exe_w = 0; exe_ld = 0; exe_rd = 0; mem_w = 0; mem_rd = 0; br_res = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ctl vectors are {pc_stall, if_id_stall, if_id_flush, id_exe_bubble}
  initial begin
    clear_inputs();
    rst_n = 1'b0;
    // A load-use hazard is present while in reset: outputs must stay quiet.
    vf = 1; vn = 1; read_rt = 1; rt = 17; exe_w = 1; exe_ld = 1; exe_rd = 17;
    #2;
    chk("reset_ctl_f", ctl_f, 4'b0000);
    chk("reset_ctl_n", ctl_n, 4'b0000);
    chk("reset_busy_f", {3'b0, busy_f}, 4'b0000);
    chk("reset_fwd_f", {fa_f, fb_f}, 4'b0000);

    // Load-use against EXE with forwarding: one cycle of hold.
    #6 rst_n = 1'b1;
    #1;
    chk("loaduse_ctl_f", ctl_f, 4'b1101);
    chk("loaduse_fwdb_f", {2'b0, fb_f}, 4'b0010);
    chk("raw_exe_ctl_n", ctl_n, 4'b1101);
    tick();
    // Load now in MEM: forwarded from MEM, no stall.
    exe_w = 0; exe_ld = 0; exe_rd = 0; mem_w = 1; mem_rd = 17;
    #1;
    chk("loadmem_ctl_f", ctl_f, 4'b0000);
    chk("loadmem_fwdb_f", {2'b0, fb_f}, 4'b0001);
    chk("raw_mem_ctl_n", ctl_n, 4'b1101);
    chk("nofwd_fwdb_n", {2'b0, fb_n}, 4'b0000);

    // EXE and MEM both write $16: EXE wins the forward.
    clear_inputs();
    vf = 1; vn = 1; read_rs = 1; rs = 16;
    exe_w = 1; exe_rd = 16; mem_w = 1; mem_rd = 16;
    #1;
    chk("prio_fwda_f", {2'b0, fa_f}, 4'b0010);
    chk("prio_ctl_f", ctl_f, 4'b0000);
    chk("prio_ctl_n", ctl_n, 4'b1101);
    chk("prio_fwda_n", {2'b0, fa_n}, 4'b0000);
    // Everything targets $0: no dependency at all.
    rs = 0; exe_rd = 0; mem_rd = 0;
    #1;
    chk("zero_fwda_f", {2'b0, fa_f}, 4'b0000);
    chk("zero_ctl_f", ctl_f, 4'b0000);
    chk("zero_ctl_n", ctl_n, 4'b0000);
    tick();

    // No-forward mode: add $17 in EXE, beq reads $16/$17.
    clear_inputs();
    vn = 1; is_branch = 1; read_rs = 1; read_rt = 1; rs = 16; rt = 17;
    exe_w = 1; exe_rd = 17;
    #1;
    chk("nofwd_stall1_n", ctl_n, 4'b1101);
    tick();
    exe_w = 0; exe_rd = 0; mem_w = 1; mem_rd = 17;
    #1;
    chk("nofwd_stall2_n", ctl_n, 4'b1101);
    tick();
    mem_w = 0; mem_rd = 0;
    #1;
    chk("br_accept_n", ctl_n, 4'b1010);
    tick();
    // BR_PEND: ID holds a flushed NOP.
    vn = 0; is_branch = 0; read_rs = 0; read_rt = 0; rs = 0; rt = 0;
    #1;
    chk("br_pend1_n", ctl_n, 4'b1010);
    tick();
    // A data hazard during BR_PEND must not produce a hold/bubble.
    vn = 1; read_rt = 1; rt = 17; exe_w = 1; exe_rd = 17;
    #1;
    chk("br_pend2_n", ctl_n, 4'b1010);
    tick();
    clear_inputs();
    br_res = 1;
    #1;
    chk("br_resolve_n", ctl_n, 4'b0010);
    tick();
    br_res = 0;
    #1;
    chk("br_idle_n", ctl_n, 4'b0000);
    // Stray resolve pulse in IDLE is ignored.
    br_res = 1;
    #1;
    chk("stray_res_n", ctl_n, 4'b0000);
    tick();
    br_res = 0;
    #1;
    chk("stray_after_n", ctl_n, 4'b0000);

    // MDU: accept mult, then mflo stalls MDU_LAT cycles.
    clear_inputs();
    vf = 1; is_mdu = 1; uses_hilo = 1;
    #1;
    chk("mult_accept_f", ctl_f, 4'b0000);
    chk("mult_busy0_f", {3'b0, busy_f}, 4'b0000);
    tick();
    is_mdu = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("mflo_busy_%0d", i), {3'b0, busy_f}, 4'b0001);
      chk($sformatf("mflo_stall_%0d", i), ctl_f, 4'b1101);
      tick();
    end
    #1;
    chk("mflo_free_busy", {3'b0, busy_f}, 4'b0000);
    chk("mflo_free_ctl", ctl_f, 4'b0000);
    tick();

    // Reset during BR_PEND with the MDU counter at 3.
    clear_inputs();
    vf = 1; is_mdu = 1; uses_hilo = 1;
    tick();
    is_mdu = 0; uses_hilo = 0; is_branch = 1;
    #1;
    chk("rst_br_accept_f", ctl_f, 4'b1010);
    tick();
    clear_inputs();
    #1;
    chk("rst_pend_ctl_f", ctl_f, 4'b1010);
    chk("rst_pend_busy_f", {3'b0, busy_f}, 4'b0001);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_ctl_f", ctl_f, 4'b0000);
    chk("rst_mid_busy_f", {3'b0, busy_f}, 4'b0000);
    #1 rst_n = 1'b1;
    #1;
    chk("rst_rel_ctl_f", ctl_f, 4'b0000);
    chk("rst_rel_busy_f", {3'b0, busy_f}, 4'b0000);
    tick();
    vf = 1; uses_hilo = 1;
    #1;
    chk("rst_hilo_ctl_f", ctl_f, 4'b0000);
    chk("rst_hilo_busy_f", {3'b0, busy_f}, 4'b0000);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Parametrised pipeline hazard controller for the 5-stage MIPS core, successor to the combinational stall unit. It detects RAW data hazards against EXE/MEM with configurable forwarding, and holds fetch with a branch-resolution FSM until the resolving stage reports the outcome. It also interlocks HI/LO users against a multi-cycle multiply/divide unit through a busy counter. It sits beside the ID stage and drives the PC, IF/ID and ID/EXE pipeline-register controls.

## Interface
- `REG_AW`, 5: register address width.
- `FWD_EN`, 1: 1 = forward and stall only on load-use; 0 = stall on any EXE/MEM RAW match.
- `MDU_LAT`, 4: multiply/divide occupancy in cycles, 1..15.
- `clk` in 1: core clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `id_valid` in 1: ID holds a real instruction.
- `id_read_rs`, `id_read_rt` in 1 each: ID reads rs/rt.
- `id_rs`, `id_rt` in REG_AW each: ID source registers.
- `id_is_branch` in 1: ID holds a branch or jump.
- `id_is_mdu` in 1: ID issues a mult/div.
- `id_uses_hilo` in 1: ID reads or writes HI/LO; mdu ops also set this.
- `exe_reg_write`, `exe_mem_read` in 1 each: EXE writes a register / is a load.
- `exe_rdes` in REG_AW: EXE destination register.
- `mem_reg_write` in 1: MEM writes a register.
- `mem_rdes` in REG_AW: MEM destination register.
- `br_resolved` in 1: one-cycle pulse from the resolving stage.
- `pc_stall` out 1: hold PC.
- `if_id_stall` out 1: hold IF/ID.
- `if_id_flush` out 1: load a NOP into IF/ID.
- `id_exe_bubble` out 1: load a NOP into ID/EXE.
- `fwd_a`, `fwd_b` out 2 each: rs/rt operand source select.
- `mdu_busy` out 1: MDU counter is non-zero.

## Operation
- **Source match:** A source matches a stage when its read flag is set, the stage's reg_write is set, the register addresses are equal, and the address is non-zero. Register $0 never matches.
- **Forwarding (FWD_EN=1):**
  - `fwd_x` = FWD_EXE (2'b10) on an EXE match, else FWD_MEM (2'b01) on a MEM match, else FWD_NONE (2'b00). EXE has priority.
  - data_stall = any EXE match while exe_mem_read=1.
- **No forwarding (FWD_EN=0):** `fwd_x` stays 2'b00. data_stall = any EXE or MEM match.
- **MDU interlock:**
  - mdu_stall = id_valid & id_uses_hilo & mdu_busy.
  - An accepted id_is_mdu loads the 4-bit counter with MDU_LAT.
  - Otherwise the counter decrements each cycle while non-zero.
- **hold:** hold = id_valid & (data_stall | mdu_stall). On hold: pc_stall=1, if_id_stall=1, id_exe_bubble=1, if_id_flush=0.
- **Acceptance:** ID is accepted when id_valid & ~hold & branch FSM is in IDLE.
- **Branch FSM, IDLE:**
  - An accepted id_is_branch asserts pc_stall=1 and if_id_flush=1 in the same cycle, so no wrong-path instruction enters.
  - Next state is BR_PEND.
- **Branch FSM, BR_PEND:**
  - Every cycle: pc_stall=1, if_id_flush=1, if_id_stall=0, id_exe_bubble=0.
  - On br_resolved: pc_stall=0 so the PC loads the external target or PC+4 mux, if_id_flush=1, next state is IDLE.
- **Ignored events:** br_resolved in IDLE is ignored. id_valid=0 produces no hazards.
- **Priority:** hold beats branch entry. A branch waiting on a data hazard stalls and enters BR_PEND only once accepted.
- **Reset:** rst_n low forces state=IDLE and counter=0, and gates every output to 0 (fwd 2'b00). Reset during BR_PEND or mid-MDU abandons the operation with no residual stall.

## Timing
- Data-hazard and forwarding outputs are combinational from the inputs, with zero latency.
- A load-use stall lasts exactly 1 cycle with FWD_EN=1.
- Without forwarding, a RAW stall lasts 2 cycles against EXE and 1 cycle against MEM.
- mdu_busy is high for exactly MDU_LAT cycles after the acceptance edge.
- A HI/LO user right behind an mdu op stalls MDU_LAT cycles.
- Branch cost is (cycles until br_resolved) + 1 fetch bubble.
- State and counter update on posedge clk. Reset is asynchronous on negedge rst_n.

## Structure
- Package `hazard_pkg`: FWD_NONE/FWD_MEM/FWD_EXE localparams and the FSM state encoding (ST_IDLE, ST_BR_PEND).
- Sub-module `hazard_raw_cmp`: one source against EXE/MEM, producing the match flags and fwd select. Instantiated for rs and rt.
- Top `hazard_ctrl`: FSM, MDU counter and output priority mux.

## Test plan
- **Load-use:** FWD_EN=1, EXE lw $s1 (exe_mem_read=1, exe_rdes=17), ID reads rt=17 -> pc_stall/if_id_stall/id_exe_bubble=1 for 1 cycle. Next cycle with the load in MEM -> fwd_b=2'b01, no stall.
- **Forward priority and $0:** EXE and MEM both write 16 and ID reads rs=16 -> fwd_a=2'b10. All writes to 0 with rs=0 -> fwd_a=2'b00, no stall.
- **No-forward mode:** FWD_EN=0, EXE add writes 17, ID beq reads 16/17 -> stall 2 cycles. Then the beq is accepted, pc_stall=1, if_id_flush=1, FSM enters BR_PEND.
- **Branch resolution:** BR_PEND with br_resolved after 2 cycles -> pc_stall=1 for 3 cycles total, 0 on the resolve cycle, then IDLE. A stray br_resolved in IDLE -> no output change.
- **MDU:** MDU_LAT=4, accept mult, then mflo in ID -> mdu_busy high 4 cycles, mflo stalled 4 cycles, accepted on the 5th.
- **Reset mid-operation:** rst_n pulsed low during BR_PEND with the counter at 3 -> all outputs 0 immediately, IDLE, counter 0 after release.
